// File: rtl/neuron_target_sequencer.sv
// neuron_target_sequencer: per-sample training step controller (forward, capture, serial error walk, learn strobe).
// Define NEURON_TARGET_SQERR_EN to accumulate truncated squared error instead of absolute error.
module neuron_target_sequencer #(
  parameter int M          = 31,
  parameter int VW         = 16,
  parameter int RATE_SHIFT = 2,
  parameter int LAT        = 1,
  parameter int ERR_W      = VW + 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [M-1:0][VW-1:0]  target,
  input  logic [M-1:0][VW-1:0]  layer_out,
  output logic                  layer_valid,
  output logic                  layer_learn,
  output logic [M-1:0][VW-1:0]  expected_out,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_W-1:0]      err_sum,
  output logic                  err_valid
);
  localparam int IW = M > 1 ? $clog2(M) : 1;
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  typedef enum logic [2:0] {IDLE, FWD, WAIT, CAP, ERR, LEARN, DONE} state_t;
  state_t state, state_d;
  logic [M-1:0][VW-1:0] tgt, cap;
  logic [IW-1:0] idx;
  logic [CW-1:0] wcnt;
  logic [ERR_W-1:0] acc, inc;
  logic [VW-1:0] t_i, c_i, ad, upd;
  logic signed [VW:0] d, sh;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? FWD : IDLE;
      FWD:     state_d = LAT == 0 ? CAP : WAIT;
      WAIT:    state_d = wcnt == CW'(LAT - 1) ? CAP : WAIT;
      CAP:     state_d = ERR;
      ERR:     state_d = idx == IW'(M - 1) ? LEARN : ERR;
      LEARN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // One lane per cycle: signed difference, floor-shifted step toward the label.
  always_comb begin
    t_i = tgt[idx];
    c_i = cap[idx];
    d   = $signed({1'b0, t_i}) - $signed({1'b0, c_i});
    sh  = d >>> RATE_SHIFT;
    ad  = d[VW] ? VW'(-d) : d[VW-1:0];
    upd = c_i + sh[VW-1:0];
  end
`ifdef NEURON_TARGET_SQERR_EN
  logic [2*VW-1:0] sq;
  always_comb begin
    sq  = (2*VW)'(ad) * (2*VW)'(ad);
    inc = ERR_W'(sq[2*VW-1:VW]);
  end
`else
  always_comb inc = ERR_W'(ad);
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tgt          <= '0;
      cap          <= '0;
      idx          <= '0;
      wcnt         <= '0;
      acc          <= '0;
      expected_out <= '0;
      err_sum      <= '0;
      err_valid    <= 1'b0;
      layer_valid  <= 1'b0;
      layer_learn  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state       <= state_d;
      layer_valid <= state_d == FWD || state_d == LEARN;
      layer_learn <= state_d == LEARN;
      busy        <= state_d != IDLE;
      done        <= state_d == DONE;
      wcnt        <= state == WAIT ? wcnt + CW'(1) : '0;
      if (state == IDLE && start) begin
        tgt <= target;
        acc <= '0;
      end
      if (state == CAP) begin
        cap <= layer_out;
        idx <= '0;
      end
      if (state == ERR) begin
        expected_out[idx] <= upd;
        acc               <= acc + inc;
        idx               <= idx + IW'(1);
      end
      if (state == LEARN) begin
        err_sum   <= acc;
        err_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_neuron_target_sequencer.sv
// tb_neuron_target_sequencer: directed scoreboard bench for the default build and a LAT=0, M=4 build.
module tb_neuron_target_sequencer;
  localparam int M = 31, VW = 16, ML = 4;
  logic clock = 0, reset_n = 0, start = 0, start4 = 0;
  logic [M-1:0][VW-1:0] target = '0, layer_out = '0, expected_out;
  logic layer_valid, layer_learn, busy, done, err_valid;
  logic [20:0] err_sum;
  logic [ML-1:0][VW-1:0] target4 = '0, out4 = '0, exp4;
  logic valid4, learn4, busy4, done4, ev4;
  logic [20:0] err4;
  int total = 0, bad = 0;
  typedef struct { logic [M-1:0][VW-1:0] e; logic [20:0] s; } exp_t;
  exp_t sbq[$];
  exp_t last;

  neuron_target_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .target(target), .layer_out(layer_out),
    .layer_valid(layer_valid), .layer_learn(layer_learn), .expected_out(expected_out),
    .busy(busy), .done(done), .err_sum(err_sum), .err_valid(err_valid));

  neuron_target_sequencer #(.M(ML), .LAT(0)) u4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .target(target4), .layer_out(out4),
    .layer_valid(valid4), .layer_learn(learn4), .expected_out(exp4),
    .busy(busy4), .done(done4), .err_sum(err4), .err_valid(ev4));

  always #5 clock = ~clock;

  function automatic exp_t model(input logic [M-1:0][VW-1:0] t, input logic [M-1:0][VW-1:0] c);
    exp_t r;
    longint sum = 0;
    for (int i = 0; i < M; i++) begin
      int di = int'(t[i]) - int'(c[i]);
      int st = di >= 0 ? di / 4 : -((-di + 3) / 4);
      longint a = di < 0 ? -di : di;
      r.e[i] = VW'(int'(c[i]) + st);
`ifdef NEURON_TARGET_SQERR_EN
      sum += (a * a) >> 16;
`else
      sum += a;
`endif
    end
    r.s = 21'(sum);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [M*VW-1:0] obs, input logic [M*VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_step(input string tag, input logic [M-1:0][VW-1:0] t,
                          input logic [M-1:0][VW-1:0] o, input bit pulses);
    int n_learn = -1, n_done = -1, nv = 0, nl = 0, nd = 0;
    exp_t x;
    target = t;
    layer_out = o;
    sbq.push_back(model(t, o));
    start = 1;
    tick();
    start = 0;
    target = ~t;
    chk({tag, "_busy0"}, 64'(busy), 64'd1);
    for (int n = 0; n < 80; n++) begin
      if (layer_valid) nv++;
      if (layer_learn) begin nl++; n_learn = n; end
      if (done) begin
        nd++;
        n_done = n;
        if (sbq.size() > 0) x = sbq.pop_front();
        chkw({tag, "_exp"}, expected_out, x.e);
        chk({tag, "_err"}, 64'(err_sum), 64'(x.s));
        chk({tag, "_ev"}, 64'(err_valid), 64'd1);
        last = x;
      end
      if (n == 3) layer_out = ~o;
      start = pulses && (n == 4 || n == 19);
      tick();
    end
    start = 0;
    sbq.delete();
    chk({tag, "_nvalid"}, 64'(nv), 64'd2);
    chk({tag, "_nlearn"}, 64'(nl), 64'd1);
    chk({tag, "_ndone"}, 64'(nd), 64'd1);
    chk({tag, "_tlearn"}, 64'(n_learn), 64'd34);
    chk({tag, "_tdone"}, 64'(n_done), 64'd35);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [M-1:0][VW-1:0] tr, orr;
    int nd, nl, d1, d2;
    exp_t x;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 64'(layer_valid), 64'd0);
    chk("rst_learn", 64'(layer_learn), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_sum), 64'd0);
    chk("rst_ev", 64'(err_valid), 64'd0);
    chkw("rst_exp", expected_out, '0);
    #3 reset_n = 1;
    tick();

    run_step("ones", {M{16'hFFFF}}, '0, 0);
    chk("ones_lane", 64'(expected_out[7]), 64'h3FFF);
`ifdef NEURON_TARGET_SQERR_EN
    chk("ones_sum", 64'(err_sum), 64'h1EFFC2);
`else
    chk("ones_sum", 64'(err_sum), 64'h1EFFE1);
`endif
    run_step("half", '0, {M{16'h8000}}, 0);
    chk("half_lane", 64'(expected_out[30]), 64'h6000);
`ifdef NEURON_TARGET_SQERR_EN
    chk("half_sum", 64'(err_sum), 64'h7C000);
`else
    chk("half_sum", 64'(err_sum), 64'hF8000);
`endif
    for (int i = 0; i < M; i++) begin
      tr[i] = VW'($urandom);
      orr[i] = VW'($urandom);
    end
    tr[0] = 16'h0000; orr[0] = 16'h0001;
    tr[1] = 16'h0001; orr[1] = 16'h0000;
    run_step("mixed", tr, orr, 1);
    chk("floor0", 64'(expected_out[0]), 64'h0);
    chk("floor1", 64'(expected_out[1]), 64'h0);
    repeat (10) tick();
    chkw("hold_exp", expected_out, last.e);

    // Reset in the middle of a step
    target = {M{16'h1234}};
    start = 1;
    tick();
    start = 0;
    repeat (14) tick();
    chk("mid_busy_pre", 64'(busy), 64'd1);
    reset_n = 0;
    #1;
    chk("mid_valid", 64'(layer_valid), 64'd0);
    chk("mid_learn", 64'(layer_learn), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_ev", 64'(err_valid), 64'd0);
    chk("mid_err", 64'(err_sum), 64'd0);
    repeat (3) tick();
    reset_n = 1;
    nd = 0;
    for (int n = 0; n < 50; n++) begin
      if (done) nd++;
      tick();
    end
    chk("mid_nodone", 64'(nd), 64'd0);
    run_step("after_rst", tr, {M{16'h00FF}}, 0);

    // Start held high: back-to-back steps
    tr = {M{16'hA5A5}};
    orr = {M{16'h1111}};
    target = tr;
    layer_out = orr;
    sbq.push_back(model(tr, orr));
    sbq.push_back(model(tr, orr));
    start = 1;
    tick();
    nd = 0; nl = 0; d1 = -1; d2 = -1;
    for (int n = 0; n < 120; n++) begin
      if (layer_learn) nl++;
      if (done) begin
        nd++;
        if (nd == 1) d1 = n; else d2 = n;
        if (sbq.size() > 0) x = sbq.pop_front();
        chkw("b2b_exp", expected_out, x.e);
        chk("b2b_err", 64'(err_sum), 64'(x.s));
        if (nd == 2) start = 0;
      end
      tick();
    end
    start = 0;
    sbq.delete();
    chk("b2b_ndone", 64'(nd), 64'd2);
    chk("b2b_nlearn", 64'(nl), 64'd2);
    chk("b2b_period", 64'(d2 - d1), 64'd37);

    // LAT=0, M=4 instance: capture happens right after the valid pulse
    target4 = {16'h0001, 16'h0000, 16'hFFFF, 16'h0000};
    out4 = {16'h0000, 16'h0001, 16'h0000, 16'h8000};
    start4 = 1;
    tick();
    start4 = 0;
    target4 = '0;
    chk("l0_valid", 64'(valid4), 64'd1);
    d1 = -1; d2 = -1;
    for (int n = 0; n < 20; n++) begin
      if (learn4) d1 = n;
      if (done4) d2 = n;
      if (n == 2) out4 = '1;
      tick();
    end
    chk("l0_tlearn", 64'(d1), 64'd6);
    chk("l0_tdone", 64'(d2), 64'd7);
    chk("l0_exp", 64'(exp4), {16'h0000, 16'h0000, 16'h3FFF, 16'h6000});
`ifdef NEURON_TARGET_SQERR_EN
    chk("l0_err", 64'(err4), 64'h13FFE);
`else
    chk("l0_err", 64'(err4), 64'h18001);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
